coin_sprite_ctrl: RTL and testbench



---
 rtl/coin_sprite_ctrl.sv | 162 ++++++++++++++++
 tb/tb_coin_sprite_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/coin_sprite_ctrl.sv
// Coin sprite sequencer: shadowed hit test, ROM addressing and 2-cycle palette index pipeline.
// Optional macro COIN_CTRL_PING_PONG_EN makes the spin animation bounce instead of wrapping.
module coin_sprite_ctrl #(
    parameter int          N_COINS    = 4,
    parameter int          FRAMES     = 8,
    parameter int          SPR_W      = 16,
    parameter int          SPR_H      = 16,
    parameter int          ROM_W      = 128,
    parameter int          FRAME_DIV  = 6,
    parameter logic [7:0]  TRANSP_IDX = 8'd0,
    localparam int         ID_W       = (N_COINS > 1) ? $clog2(N_COINS) : 1
) (
    input  logic                    vga_clk,
    input  logic                    reset_n,
    input  logic                    vs,
    input  logic                    blank,
    input  logic [9:0]              DrawX,
    input  logic [9:0]              DrawY,
    input  logic                    anim_en,
    input  logic [10*N_COINS-1:0]   coin_x,
    input  logic [10*N_COINS-1:0]   coin_y,
    input  logic [N_COINS-1:0]      coin_en,
    output logic [10:0]             rom_address,
    input  logic [7:0]              rom_q,
    output logic                    pix_valid,
    output logic [7:0]              pix_index,
    output logic [ID_W-1:0]         hit_id,
    output logic [2:0]              anim_frame
);

    typedef enum logic [1:0] {ACTIVE, LATCH, VSYNC} state_t;

    state_t                 state, state_nxt;
    logic                   vs_d;
    logic [5:0]             div_cnt;
    logic [10*N_COINS-1:0]  sh_x, sh_y;
    logic [N_COINS-1:0]     sh_en;
`ifdef COIN_CTRL_PING_PONG_EN
    logic                   dir_up;
`endif

    logic                   vld_p0;
    logic [ID_W-1:0]        id_p0;
    logic [10:0]            addr_p0;
    logic                   vld_p1, blank_p1;
    logic [ID_W-1:0]        id_p1;
    logic [10:0]            cx, cy, px, py;

    always_comb begin
        state_nxt = state;
        case (state)
            ACTIVE:  if (vs_d && !vs) state_nxt = LATCH;
            LATCH:   state_nxt = VSYNC;
            VSYNC:   if (vs) state_nxt = ACTIVE;
            default: state_nxt = ACTIVE;
        endcase
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ACTIVE;
            vs_d  <= 1'b1;
        end else begin
            state <= state_nxt;
            vs_d  <= vs;
        end
    end

    // Shadow copy and animation step happen only in the single LATCH cycle
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_x       <= '0;
            sh_y       <= '0;
            sh_en      <= '0;
            div_cnt    <= '0;
            anim_frame <= '0;
`ifdef COIN_CTRL_PING_PONG_EN
            dir_up     <= 1'b1;
`endif
        end else if (state == LATCH) begin
            sh_x  <= coin_x;
            sh_y  <= coin_y;
            sh_en <= coin_en;
            if (anim_en) begin
                if (div_cnt == 6'(FRAME_DIV - 1)) begin
                    div_cnt <= '0;
`ifdef COIN_CTRL_PING_PONG_EN
                    if (dir_up) begin
                        if (anim_frame == 3'(FRAMES - 1)) begin
                            dir_up     <= 1'b0;
                            anim_frame <= anim_frame - 3'd1;
                        end else begin
                            anim_frame <= anim_frame + 3'd1;
                        end
                    end else begin
                        if (anim_frame == 3'd0) begin
                            dir_up     <= 1'b1;
                            anim_frame <= 3'd1;
                        end else begin
                            anim_frame <= anim_frame - 3'd1;
                        end
                    end
`else
                    anim_frame <= (anim_frame == 3'(FRAMES - 1)) ? 3'd0 : anim_frame + 3'd1;
`endif
                end else begin
                    div_cnt <= div_cnt + 6'd1;
                end
            end
        end
    end

    // Stage p0: priority hit test (lowest index wins) and address formation
    always_comb begin
        vld_p0  = 1'b0;
        id_p0   = '0;
        addr_p0 = '0;
        cx      = '0;
        cy      = '0;
        px      = {1'b0, DrawX};
        py      = {1'b0, DrawY};
        for (int i = N_COINS - 1; i >= 0; i--) begin
            cx = {1'b0, sh_x[10*i +: 10]};
            cy = {1'b0, sh_y[10*i +: 10]};
            if (sh_en[i] && px >= cx && px < cx + 11'(SPR_W) &&
                py >= cy && py < cy + 11'(SPR_H)) begin
                vld_p0  = 1'b1;
                id_p0   = ID_W'(i);
                addr_p0 = 11'(anim_frame) * 11'(SPR_W) + (px - cx) + (py - cy) * 11'(ROM_W);
            end
        end
    end

    // Stage p1: registered ROM address; ROM samples it on the following negedge
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_address <= '0;
            vld_p1      <= 1'b0;
            blank_p1    <= 1'b0;
            id_p1       <= '0;
        end else begin
            rom_address <= addr_p0;
            vld_p1      <= vld_p0;
            blank_p1    <= blank;
            id_p1       <= id_p0;
        end
    end

    // Stage p2: gate returned palette index
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_index <= '0;
            pix_valid <= 1'b0;
            hit_id    <= '0;
        end else begin
            pix_index <= rom_q;
            pix_valid <= vld_p1 & blank_p1 & (rom_q != TRANSP_IDX);
            hit_id    <= id_p1;
        end
    end

endmodule

// File: tb/tb_coin_sprite_ctrl.sv
// Directed bench for coin_sprite_ctrl with a negedge-clocked ROM model.
module tb_coin_sprite_ctrl;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic        vs;
    logic        blank;
    logic [9:0]  DrawX, DrawY;
    logic        anim_en;
    logic [39:0] coin_x, coin_y;
    logic [3:0]  coin_en;
    logic [10:0] rom_address;
    logic [7:0]  rom_q;
    logic        pix_valid;
    logic [7:0]  pix_index;
    logic [1:0]  hit_id;
    logic [2:0]  anim_frame;

    logic [7:0]  rom_mem [0:2047];
    int          nvec = 0;
    int          nerr = 0;

    coin_sprite_ctrl dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .vs(vs), .blank(blank),
        .DrawX(DrawX), .DrawY(DrawY), .anim_en(anim_en),
        .coin_x(coin_x), .coin_y(coin_y), .coin_en(coin_en),
        .rom_address(rom_address), .rom_q(rom_q),
        .pix_valid(pix_valid), .pix_index(pix_index),
        .hit_id(hit_id), .anim_frame(anim_frame)
    );

    always #5 vga_clk = ~vga_clk;

    always @(negedge vga_clk) rom_q <= rom_mem[rom_address];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic vsync_pulse();
        vs = 1'b0;
        repeat (3) tick();
        vs = 1'b1;
        repeat (3) tick();
    endtask

    task automatic vsyncs(input int n);
        for (int k = 0; k < n; k++) vsync_pulse();
    endtask

    task automatic set_coin(input int i, input int x, input int y, input logic en);
        coin_x[10*i +: 10] = 10'(x);
        coin_y[10*i +: 10] = 10'(y);
        coin_en[i]         = en;
    endtask

    // Apply one pixel and check address one cycle later and pixel outputs two cycles later
    task automatic probe(input string tag, input int x, input int y,
                         input logic exp_hit, input int exp_addr, input int exp_id);
        logic [10:0] a;
        a     = exp_hit ? 11'(exp_addr) : 11'd0;
        DrawX = 10'(x);
        DrawY = 10'(y);
        tick();
        check({tag, "_addr"}, 32'(rom_address), 32'(a));
        tick();
        check({tag, "_valid"}, 32'(pix_valid),
              32'(exp_hit && blank && (rom_mem[a] != 8'd0)));
        if (exp_hit) begin
            check({tag, "_index"}, 32'(pix_index), 32'(rom_mem[a]));
            check({tag, "_id"}, 32'(hit_id), 32'(exp_id));
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom_mem[i] = 8'(((i * 7 + 3) % 251) + 1);
        rom_mem[650] = 8'd0;

        reset_n = 1'b0; vs = 1'b1; blank = 1'b1; anim_en = 1'b0;
        DrawX = '0; DrawY = '0; coin_x = '0; coin_y = '0; coin_en = '0;
        set_coin(0, 100, 100, 1'b1);

        for (int k = 0; k < 6; k++) begin
            vs    = k[0];
            DrawX = 10'(100 + k);
            DrawY = 10'd100;
            tick();
        end
        check("rst_addr",  32'(rom_address), 0);
        check("rst_valid", 32'(pix_valid), 0);
        check("rst_index", 32'(pix_index), 0);
        check("rst_id",    32'(hit_id), 0);
        check("rst_frame", 32'(anim_frame), 0);

        vs = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        probe("unlatched", 100, 100, 1'b0, 0, 0);

        vsync_pulse();
        check("frame0", 32'(anim_frame), 0);
        probe("basic", 103, 102, 1'b1, 259, 0);
        probe("basic_miss", 116, 102, 1'b0, 0, 0);

        set_coin(0, 200, 50, 1'b1);
        set_coin(1, 205, 50, 1'b1);
        set_coin(2, 0, 0, 1'b0);
        set_coin(3, 630, 470, 1'b1);
        vsync_pulse();
        probe("overlap_transp", 210, 55, 1'b1, 650, 0);
        probe("overlap_c1", 218, 55, 1'b1, 13 + 5 * 128, 1);

        probe("edge", 639, 479, 1'b1, 9 + 9 * 128, 3);
        probe("edge_nextline", 0, 480, 1'b0, 0, 0);
        blank = 1'b0;
        probe("edge_blank", 639, 479, 1'b1, 9 + 9 * 128, 3);
        blank = 1'b1;

        set_coin(0, 100, 100, 1'b1);
        vsync_pulse();
        coin_x[9:0] = 10'd300;
        DrawX = 10'd0;
        DrawY = 10'd240;
        tick();
        probe("tear_old", 103, 102, 1'b1, 259, 0);
        probe("tear_new_early", 303, 102, 1'b0, 0, 0);
        vsync_pulse();
        probe("tear_new", 303, 102, 1'b1, 259, 0);
        probe("tear_old_gone", 103, 102, 1'b0, 0, 0);

        anim_en = 1'b1;
        vsyncs(5);
        check("anim_5", 32'(anim_frame), 0);
        vsyncs(1);
        check("anim_6", 32'(anim_frame), 1);
        probe("anim_addr", 303, 102, 1'b1, 16 + 259, 0);
        vsyncs(36);
        check("anim_42", 32'(anim_frame), 7);
        vsyncs(3);
        anim_en = 1'b0;
        vsyncs(12);
        check("anim_hold", 32'(anim_frame), 7);
        anim_en = 1'b1;
        vsyncs(3);
`ifdef COIN_CTRL_PING_PONG_EN
        check("anim_48", 32'(anim_frame), 6);
`else
        check("anim_48", 32'(anim_frame), 0);
`endif
        vsyncs(6);
`ifdef COIN_CTRL_PING_PONG_EN
        check("anim_54", 32'(anim_frame), 5);
`else
        check("anim_54", 32'(anim_frame), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
